// File: rtl/arrow_judge.sv
// Grades button presses against arrows crossing the target line and keeps score/combo counters.
// Latency: grades and counters are registered one clock after the press or auto-miss cycle.
// Backpressure: none; every cycle is evaluated and results are one-cycle pulses.
module arrow_judge #(
    parameter int CORDW        = 10,
    parameter int ARROW_COUNT  = 4,
    parameter int ARROWY_BEGIN = 480,
    parameter int TARGET_Y     = 60,
    parameter int PERFECT_WIN  = 4,
    parameter int GOOD_WIN     = 12,
    parameter int PERFECT_PTS  = 100,
    parameter int GOOD_PTS     = 50,
    parameter int SCOREW       = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         btn_left_i,
    input  logic                         btn_up_i,
    input  logic                         btn_down_i,
    input  logic                         btn_right_i,
    input  logic [CORDW*ARROW_COUNT-1:0] arrow_y_i,
    output logic [3:0]                   judge_valid_o,
    output logic [7:0]                   judge_grade_o,
    output logic [SCOREW-1:0]            score_o,
    output logic [7:0]                   combo_o,
    output logic [7:0]                   max_combo_o
);

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_PERF = 2'b01;
    localparam logic [1:0] G_GOOD = 2'b10;
    localparam logic [1:0] G_MISS = 2'b11;

    localparam logic [CORDW-1:0]  Y_BEGIN  = CORDW'(ARROWY_BEGIN);
    localparam logic [CORDW-1:0]  Y_AUTO   = CORDW'(TARGET_Y - GOOD_WIN);
    localparam logic [CORDW:0]    TGT_W    = (CORDW+1)'(TARGET_Y);
    localparam logic [CORDW:0]    PWIN_W   = (CORDW+1)'(PERFECT_WIN);
    localparam logic [CORDW:0]    GWIN_W   = (CORDW+1)'(GOOD_WIN);
    localparam logic [SCOREW+1:0] PPTS_W   = (SCOREW+2)'(PERFECT_PTS);
    localparam logic [SCOREW+1:0] GPTS_W   = (SCOREW+2)'(GOOD_PTS);
    localparam logic [SCOREW+1:0] SCORE_MX = {2'b00, {SCOREW{1'b1}}};

    typedef enum logic {LOCKED, ARMED} lane_state_t;

    lane_state_t      state_q [ARROW_COUNT];
    logic [3:0]       btn;
    logic [3:0]       btn_q;
    logic [3:0]       press;
    logic [3:0]       at_begin;
    logic [1:0]       grade_d [ARROW_COUNT];
    logic [SCOREW+1:0] score_sum;
    logic [SCOREW-1:0] score_d;
    logic [8:0]       combo_sum;
    logic [7:0]       combo_d;
    logic [2:0]       hits;
    logic             any_miss;

    always_comb begin
        btn   = {btn_left_i, btn_up_i, btn_down_i, btn_right_i};
        press = btn & ~btn_q;
    end

    always_comb begin
        logic [CORDW-1:0] y;
        logic [CORDW:0]   yw;
        logic [CORDW:0]   d;
        at_begin  = '0;
        hits      = '0;
        any_miss  = 1'b0;
        score_sum = {2'b00, score_o};
        y         = '0;
        yw        = '0;
        d         = '0;
        for (int k = 0; k < ARROW_COUNT; k++) begin
            grade_d[k]  = G_NONE;
            y           = arrow_y_i[k*CORDW +: CORDW];
            yw          = {1'b0, y};
            d           = (yw >= TGT_W) ? (yw - TGT_W) : (TGT_W - yw);
            at_begin[k] = (y == Y_BEGIN);
            if (state_q[k] == ARMED && y < Y_BEGIN) begin
                // A press wins over the auto-miss when both happen in one cycle.
                if (press[k]) begin
                    if (d <= PWIN_W)      grade_d[k] = G_PERF;
                    else if (d <= GWIN_W) grade_d[k] = G_GOOD;
                    else                  grade_d[k] = G_MISS;
                end else if (y < Y_AUTO) begin
                    grade_d[k] = G_MISS;
                end
            end
            case (grade_d[k])
                G_PERF: begin hits = hits + 3'd1; score_sum = score_sum + PPTS_W; end
                G_GOOD: begin hits = hits + 3'd1; score_sum = score_sum + GPTS_W; end
                G_MISS: any_miss = 1'b1;
                default: ;
            endcase
        end
        score_d   = (score_sum > SCORE_MX) ? SCORE_MX[SCOREW-1:0] : score_sum[SCOREW-1:0];
        combo_sum = {1'b0, combo_o} + {6'd0, hits};
        if (any_miss)               combo_d = 8'd0;
        else if (combo_sum > 9'd255) combo_d = 8'd255;
        else                         combo_d = combo_sum[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            btn_q         <= '0;
            judge_valid_o <= '0;
            judge_grade_o <= '0;
            score_o       <= '0;
            combo_o       <= '0;
            max_combo_o   <= '0;
            for (int k = 0; k < ARROW_COUNT; k++) state_q[k] <= LOCKED;
        end else begin
            btn_q <= btn;
            for (int k = 0; k < ARROW_COUNT; k++) begin
                // Arming cycle ignores the press: the arrow is not yet in flight.
                if (state_q[k] == LOCKED) begin
                    if (at_begin[k]) state_q[k] <= ARMED;
                end else if (grade_d[k] != G_NONE) begin
                    state_q[k] <= LOCKED;
                end
                judge_valid_o[k]          <= (grade_d[k] != G_NONE);
                judge_grade_o[2*k +: 2]   <= grade_d[k];
            end
            score_o     <= score_d;
            combo_o     <= combo_d;
            max_combo_o <= (combo_d > max_combo_o) ? combo_d : max_combo_o;
        end
    end

endmodule
